// File: rtl/pixel_write_sink_pkg.sv
// Shared screen geometry, field widths, FSM encoding and address helper for pixel_write_sink.
package pixel_write_sink_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int FB_WORDS = SCREEN_W * SCREEN_H;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 18;
    localparam int ADDR_W   = 15;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CLEAR_WAIT = 2'd1,
        ST_CLEAR      = 2'd2,
        ST_CLEAR_FIN  = 2'd3
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    // y*160 + x as shift-adds, wrapped to the framebuffer address width
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                      input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] yw;
        yw = ADDR_W'(y);
        return (yw << 7) + (yw << 5) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/pixel_write_sink_if.sv
// Pixel-write bus from the drawers plus the framebuffer write port, grouped for pixel_write_sink.
interface pixel_write_sink_if;
    import pixel_write_sink_pkg::*;

    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_write;
    logic                busy;

    logic [ADDR_W-1:0]   fb_addr;
    logic [COLOUR_W-1:0] fb_data;
    logic                fb_we;
    logic                fb_ready;

    modport master (
        output vga_x, vga_y, vga_colour, vga_write, fb_ready,
        input  busy, fb_addr, fb_data, fb_we
    );

    modport slave (
        input  vga_x, vga_y, vga_colour, vga_write, fb_ready,
        output busy, fb_addr, fb_data, fb_we
    );

endinterface

// File: rtl/pixel_write_sink_fifo.sv
// pixel_fifo: synchronous FIFO with registered occupancy count; full/empty derive from the count.
module pixel_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 33
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // Storage carries no reset; only the pointers define validity
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pixel_write_sink.sv
// Pixel-write sink: FIFO, address conversion, framebuffer output register and screen-clear FSM.
// Optional build macro PIXEL_SINK_CLIP_EN discards off-screen coordinates at push time.
module pixel_write_sink
    import pixel_write_sink_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                clock,
    input  logic                resetn,
    pixel_write_sink_if.slave   pix,
    input  logic                clear_start,
    input  logic [COLOUR_W-1:0] clear_colour,
    output logic                clear_done,
    output logic                overflow
);

    state_t              state;
    state_t              state_next;
    pixel_t              push_pix;
    pixel_t              head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                in_range;
    logic                push;
    logic                pop;
    logic                out_free;
    logic                load_clear;
    logic                clear_step;
    logic                clear_last;
    logic                we_p1;
    logic [ADDR_W-1:0]   addr_p1;
    logic [COLOUR_W-1:0] data_p1;
    logic [ADDR_W-1:0]   clr_cnt;

`ifdef PIXEL_SINK_CLIP_EN
    assign in_range = (pix.vga_x < X_W'(SCREEN_W)) && (pix.vga_y < Y_W'(SCREEN_H));
`else
    assign in_range = 1'b1;
`endif

    assign push_pix   = '{x: pix.vga_x, y: pix.vga_y, colour: pix.vga_colour};
    assign push       = pix.vga_write && in_range && !fifo_full;
    assign pix.busy   = fifo_full;
    assign out_free   = !we_p1 || pix.fb_ready;
    assign clear_last = (clr_cnt == ADDR_W'(FB_WORDS - 1));

    pixel_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W ($bits(pixel_t))
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (push_pix),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) overflow <= 1'b0;
        else if (pix.vga_write && in_range && fifo_full) overflow <= 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    // Popping stops as soon as a clear is requested so the output register can go idle
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load_clear = 1'b0;
        clear_step = 1'b0;
        clear_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clear_start) state_next = ST_CLEAR_WAIT;
                else             pop = out_free && !fifo_empty;
            end
            ST_CLEAR_WAIT: begin
                if (out_free) begin
                    load_clear = 1'b1;
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (pix.fb_ready) begin
                    clear_step = 1'b1;
                    if (clear_last) state_next = ST_CLEAR_FIN;
                end
            end
            ST_CLEAR_FIN: begin
                clear_done = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output stage p1: one framebuffer write held until accepted
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            we_p1   <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            clr_cnt <= '0;
        end else if (pop) begin
            we_p1   <= 1'b1;
            addr_p1 <= pixel_addr(head.x, head.y);
            data_p1 <= head.colour;
        end else if (load_clear) begin
            we_p1   <= 1'b1;
            addr_p1 <= '0;
            data_p1 <= clear_colour;
            clr_cnt <= '0;
        end else if (clear_step) begin
            if (clear_last) begin
                we_p1 <= 1'b0;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
                addr_p1 <= clr_cnt + 1'b1;
            end
        end else if (we_p1 && pix.fb_ready) begin
            we_p1 <= 1'b0;
        end
    end

    assign pix.fb_we   = we_p1;
    assign pix.fb_addr = addr_p1;
    assign pix.fb_data = data_p1;

endmodule

// File: tb/tb_pixel_write_sink.sv
// Self-checking bench for pixel_write_sink: queue-based write-order model plus directed literal checks.
module tb_pixel_write_sink;
    import pixel_write_sink_pkg::*;

    localparam int DEPTH = 8;

    logic                clock = 1'b0;
    logic                resetn;
    logic                clear_start;
    logic [COLOUR_W-1:0] clear_colour;
    logic                clear_done;
    logic                overflow;

    pixel_write_sink_if pif ();

    pixel_write_sink #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .pix          (pif),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .clear_done   (clear_done),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected writes in order, screen clear as an address sweep
    typedef struct {
        logic [ADDR_W-1:0]   addr;
        logic [COLOUR_W-1:0] colour;
    } exp_t;

    exp_t                pixq[$];
    exp_t                e;
    bit                  clr_active = 0;
    int                  clr_idx = 0;
    logic [COLOUR_W-1:0] clr_col = '0;
    bit                  done_next = 0;
    bit                  exp_done_now = 0;
    bit                  exp_ovf = 0;
    bit                  prev_hold = 0;
    logic [ADDR_W-1:0]   prev_addr = '0;
    logic [COLOUR_W-1:0] prev_data = '0;
    int                  n_acc = 0;
    int                  n_clr = 0;

    function automatic bit on_screen(input int x, input int y);
`ifdef PIXEL_SINK_CLIP_EN
        return (x < SCREEN_W) && (y < SCREEN_H);
`else
        return 1'b1;
`endif
    endfunction

    always @(negedge clock) begin
        if (!resetn) begin
            pixq.delete();
            clr_active = 0;
            clr_idx    = 0;
            done_next  = 0;
            exp_ovf    = 0;
            prev_hold  = 0;
        end else begin
            exp_done_now = done_next;
            done_next    = 0;
            chk("clear_done", 32'(clear_done), 32'(exp_done_now));
            chk("overflow", 32'(overflow), 32'(exp_ovf));
            if (pixq.size() > DEPTH) chk("busy_when_full", 32'(pif.busy), 1);
            if (pixq.size() < DEPTH) chk("busy_when_not_full", 32'(pif.busy), 0);
            if (prev_hold) begin
                chk("hold_we", 32'(pif.fb_we), 1);
                chk("hold_addr", 32'(pif.fb_addr), 32'(prev_addr));
                chk("hold_data", 32'(pif.fb_data), 32'(prev_data));
            end
            if (pif.fb_we && pif.fb_ready) begin
                n_acc++;
                if (clr_active && clr_idx < FB_WORDS) begin
                    chk("clear_addr", 32'(pif.fb_addr), 32'(clr_idx));
                    chk("clear_data", 32'(pif.fb_data), 32'(clr_col));
                    clr_idx++;
                    n_clr++;
                    if (clr_idx == FB_WORDS) done_next = 1;
                end else if (pixq.size() > 0) begin
                    e = pixq.pop_front();
                    chk("pix_addr", 32'(pif.fb_addr), 32'(e.addr));
                    chk("pix_data", 32'(pif.fb_data), 32'(e.colour));
                end else begin
                    chk("unexpected_write", 32'(pif.fb_we), 0);
                end
            end
            prev_hold = pif.fb_we && !pif.fb_ready;
            prev_addr = pif.fb_addr;
            prev_data = pif.fb_data;
            if (pif.vga_write && on_screen(int'(pif.vga_x), int'(pif.vga_y))) begin
                if (pif.busy) begin
                    exp_ovf = 1;
                end else begin
                    e.addr   = ADDR_W'((int'(pif.vga_y) * SCREEN_W + int'(pif.vga_x)) % 32768);
                    e.colour = pif.vga_colour;
                    pixq.push_back(e);
                end
            end
            if (clear_start && !clr_active) begin
                clr_active = 1;
                clr_idx    = 0;
                clr_col    = clear_colour;
            end
            if (exp_done_now) clr_active = 0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_pixel(input int x, input int y, input int c);
        pif.vga_x      = X_W'(x);
        pif.vga_y      = Y_W'(y);
        pif.vga_colour = COLOUR_W'(c);
        pif.vga_write  = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, 32'(pif.busy), 0);
        chk({tag, "_clear_done"}, 32'(clear_done), 0);
        chk({tag, "_fb_we"}, 32'(pif.fb_we), 0);
        chk({tag, "_fb_addr"}, 32'(pif.fb_addr), 0);
        chk({tag, "_fb_data"}, 32'(pif.fb_data), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
    endtask

    initial begin
        int base;
        int cyc;
        resetn         = 1'b0;
        clear_start    = 1'b0;
        clear_colour   = '0;
        pif.vga_x      = '0;
        pif.vga_y      = '0;
        pif.vga_colour = '0;
        pif.vga_write  = 1'b0;
        pif.fb_ready   = 1'b1;
        repeat (3) tick();
        check_reset_values("reset");
        resetn = 1'b1;
        tick();

        // Single write: two-cycle latency, one-cycle write
        drive_pixel(5, 3, 18'h3FFFF);
        tick();
        pif.vga_write = 1'b0;
        chk("single_we_early", 32'(pif.fb_we), 0);
        tick();
        chk("single_we", 32'(pif.fb_we), 1);
        chk("single_addr", 32'(pif.fb_addr), 485);
        chk("single_data", 32'(pif.fb_data), 32'h3FFFF);
        tick();
        chk("single_we_after", 32'(pif.fb_we), 0);

        // Bottom-right corner
        drive_pixel(159, 119, 18'h12345);
        tick();
        pif.vga_write = 1'b0;
        tick();
        chk("corner_addr", 32'(pif.fb_addr), 19199);
        chk("corner_data", 32'(pif.fb_data), 32'h12345);
        tick();

        // Off-screen column
        drive_pixel(160, 0, 18'h00777);
        tick();
        pif.vga_write = 1'b0;
        tick();
`ifdef PIXEL_SINK_CLIP_EN
        chk("clip_no_we", 32'(pif.fb_we), 0);
`else
        chk("noclip_addr", 32'(pif.fb_addr), 160);
`endif
        tick();
        chk("clip_overflow", 32'(overflow), 0);

        // fb_ready toggling during a 4-pixel burst
        base = n_acc;
        for (int i = 0; i < 16; i++) begin
            if (i < 4) drive_pixel(i + 1, 10 + i, 18'h100 + i);
            else       pif.vga_write = 1'b0;
            pif.fb_ready = ~pif.fb_ready;
            tick();
        end
        pif.vga_write = 1'b0;
        pif.fb_ready  = 1'b1;
        repeat (4) tick();
        chk("toggle_count", 32'(n_acc - base), 4);

        // Fill with fb_ready low: 9 held, 10th dropped
        pif.fb_ready = 1'b0;
        base = n_acc;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) chk("busy_before_9th", 32'(pif.busy), 0);
            if (i == 9) chk("busy_before_10th", 32'(pif.busy), 1);
            drive_pixel(i * 10, i, 1000 * i + 1);
            tick();
        end
        pif.vga_write = 1'b0;
        chk("overflow_set", 32'(overflow), 1);
        chk("busy_held", 32'(pif.busy), 1);
        pif.fb_ready = 1'b1;
        tick();
        chk("busy_after_pop", 32'(pif.busy), 0);
        repeat (12) tick();
        chk("fill_count", 32'(n_acc - base), 9);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            pif.fb_ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) != 0)
                drive_pixel($urandom_range(0, 169), $urandom_range(0, 127), $urandom_range(0, 18'h3FFFF));
            else
                pif.vga_write = 1'b0;
            tick();
        end
        pif.vga_write = 1'b0;
        pif.fb_ready  = 1'b1;
        repeat (20) tick();
        chk("random_drained", 32'(pixq.size()), 0);

        // Full-screen clear with three pixels pushed mid-clear
        base         = n_clr;
        clear_colour = 18'h00ABC;
        clear_start  = 1'b1;
        tick();
        clear_start = 1'b0;
        cyc = 0;
        while (!clear_done && cyc < 20000) begin
            tick();
            cyc++;
            if (cyc >= 50 && cyc < 53) drive_pixel(cyc, cyc - 40, 18'h2A000 + cyc);
            else pif.vga_write = 1'b0;
            clear_start = (cyc == 60);
        end
        pif.vga_write = 1'b0;
        clear_start   = 1'b0;
        chk("clear_done_seen", 32'(clear_done), 1);
        chk("clear_done_cycle", 32'(cyc + 1), 19202);
        tick();
        chk("clear_done_pulse", 32'(clear_done), 0);
        chk("clear_count", 32'(n_clr - base), 19200);
        repeat (8) tick();
        chk("post_clear_drained", 32'(pixq.size()), 0);

        // Reset in the middle of a clear
        clear_colour = 18'h15555;
        clear_start  = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (100) tick();
        #2;
        resetn = 1'b0;
        #1;
        check_reset_values("midreset");
        repeat (2) tick();
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("no_done_after_reset", 32'(clear_done), 0);
        end
        chk("post_reset_we", 32'(pif.fb_we), 0);
        drive_pixel(7, 2, 18'h0F0F0);
        tick();
        pif.vga_write = 1'b0;
        tick();
        chk("post_reset_addr", 32'(pif.fb_addr), 327);
        chk("post_reset_data", 32'(pif.fb_data), 32'h0F0F0);
        repeat (4) tick();
        chk("final_drained", 32'(pixq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
